tank_unit: RTL and testbench

Parametrised player-tank controller for the tank game core, one instance per player. It owns tank position, heading, HP, fire cooldown with press buffering, one selectable skill, post-hit invulnerability and optional timed respawn. Moves are wall-checked by probing every pixel of the tank's leading edge against an external wall map with a 1-cycle lookup latency; probing runs at clk rate, not game_tick rate. The block sits between the input decoder and the bullet/wall/render units.

---
 rtl/tank_unit.sv | 265 ++++++++++++++++++++++++++
 tb/tb_tank_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tank_unit.sv
// Player tank controller: position, heading, HP, fire cooldown/buffer, one skill,
// invulnerability and respawn. Moves are wall-checked edge-pixel by edge-pixel at clk rate.
module tank_unit #(
  parameter int TANK_W        = 3,
  parameter int TANK_H        = 4,
  parameter int INIT_X        = 20,
  parameter int INIT_Y        = 70,
  parameter int INIT_DIR      = 3,
  parameter int MIN_X         = 4,
  parameter int MAX_X         = 193,
  parameter int MIN_Y         = 4,
  parameter int MAX_Y         = 136,
  parameter int MAX_HP        = 3,
  parameter int SPEED_NORMAL  = 1,
  parameter int SPEED_BOOST   = 2,
  parameter int BOOST_TICKS   = 300,
  parameter int FIRE_COOLDOWN = 15,
  parameter int FIRE_BUFFER   = 6,
  parameter int PIERCE_INIT   = 3,
  parameter int SPREAD_INIT   = 3,
  parameter int INVULN_TICKS  = 30,
  parameter int RESPAWN_TICKS = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       game_tick,
  input  logic       game_start,
  input  logic       move_up,
  input  logic       move_down,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       fire,
  input  logic       use_skill,
  input  logic [1:0] skill_type,
  output logic [7:0] check_x,
  output logic [7:0] check_y,
  output logic       check_valid,
  input  logic       hit_wall,
  input  logic       hit,
  output logic       fire_bullet,
  output logic       fire_spread,
  output logic       fire_pierce,
  output logic [7:0] bullet_x,
  output logic [7:0] bullet_y,
  output logic [1:0] bullet_dir,
  output logic [7:0] pos_x,
  output logic [7:0] pos_y,
  output logic [1:0] dir,
  output logic [2:0] hp,
  output logic       alive,
  output logic       invuln,
  output logic       busy,
  output logic       shield_active,
  output logic       boost_active,
  output logic [2:0] pierce_count,
  output logic [2:0] spread_count
);
  localparam logic [7:0]  IX   = 8'(INIT_X);
  localparam logic [7:0]  IY   = 8'(INIT_Y);
  localparam logic [1:0]  IDIR = 2'(INIT_DIR);
  localparam logic [7:0]  MNX  = 8'(MIN_X);
  localparam logic [7:0]  MNY  = 8'(MIN_Y);
  localparam logic [8:0]  MXX9 = 9'(MAX_X);
  localparam logic [8:0]  MXY9 = 9'(MAX_Y);
  localparam logic [7:0]  MXX  = 8'(MAX_X);
  localparam logic [7:0]  MXY  = 8'(MAX_Y);
  localparam logic [2:0]  HP0  = 3'(MAX_HP);
  localparam logic [7:0]  SPN  = 8'(SPEED_NORMAL);
  localparam logic [7:0]  SPB  = 8'(SPEED_BOOST);
  localparam logic [15:0] BT   = 16'(BOOST_TICKS);
  localparam logic [7:0]  FC   = 8'(FIRE_COOLDOWN);
  localparam logic [7:0]  FB   = 8'(FIRE_BUFFER);
  localparam logic [15:0] IT   = 16'(INVULN_TICKS);
  localparam logic [15:0] RT   = 16'(RESPAWN_TICKS);
  localparam logic [7:0]  TW   = 8'(TANK_W);
  localparam logic [7:0]  TH   = 8'(TANK_H);
  localparam logic [7:0]  TW2  = 8'(TANK_W / 2);
  localparam logic [7:0]  TH2  = 8'(TANK_H / 2);

  typedef enum logic [1:0] {IDLE, PROBE, DRAIN} state_t;

  state_t      state;
  logic        armed, fire_q, vert, blk;
  logic [7:0]  fbuf, cd, nx_r, ny_r;
  logic [15:0] bt, it, rt;
  logic [3:0]  k;

  logic [7:0]  spd, nx, ny, px, py, bx, by;
  logic [8:0]  sum_x, sum_y;
  logic [1:0]  mdir;
  logic [3:0]  nlast;
  logic        mv, do_move, do_fire, take, kill;

  assign busy = (state != IDLE);

  always_comb begin
    spd   = boost_active ? SPB : SPN;
    mv    = 1'b1;
    mdir  = dir;
    if (move_up)         mdir = 2'd0;
    else if (move_down)  mdir = 2'd1;
    else if (move_left)  mdir = 2'd2;
    else if (move_right) mdir = 2'd3;
    else                 mv   = 1'b0;
    sum_x = {1'b0, pos_x} + {1'b0, spd};
    sum_y = {1'b0, pos_y} + {1'b0, spd};
    nx = pos_x;
    ny = pos_y;
    px = pos_x;
    py = pos_y;
    case (mdir)
      2'd0: begin
        ny = ({1'b0, pos_y} < {1'b0, MNY} + {1'b0, spd}) ? MNY : pos_y - spd;
        py = ny;
      end
      2'd1: begin
        ny = (sum_y > MXY9) ? MXY : sum_y[7:0];
        py = ny + TH - 8'd1;
      end
      2'd2: begin
        nx = ({1'b0, pos_x} < {1'b0, MNX} + {1'b0, spd}) ? MNX : pos_x - spd;
        px = nx;
      end
      default: begin
        nx = (sum_x > MXX9) ? MXX : sum_x[7:0];
        px = nx + TW - 8'd1;
      end
    endcase
    case (dir)
      2'd0:    begin bx = pos_x + TW2;  by = pos_y - 8'd2; end
      2'd1:    begin bx = pos_x + TW2;  by = pos_y + TH;   end
      2'd2:    begin bx = pos_x - 8'd2; by = pos_y + TH2;  end
      default: begin bx = pos_x + TW;   by = pos_y + TH2;  end
    endcase
    nlast   = vert ? 4'(TANK_W - 1) : 4'(TANK_H - 1);
    do_move = game_tick && (state == IDLE) && alive && armed && mv;
    do_fire = game_tick && (state == IDLE) && alive && armed && (fbuf != 8'd0) && (cd == 8'd0);
    take    = hit && alive && !invuln;
    kill    = take && !shield_active && (hp == 3'd1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE; armed <= 1'b0; fire_q <= 1'b0; vert <= 1'b0; blk <= 1'b0;
      fbuf <= '0; cd <= '0; nx_r <= '0; ny_r <= '0; bt <= '0; it <= '0; rt <= '0; k <= '0;
      check_x <= '0; check_y <= '0; check_valid <= 1'b0;
      fire_bullet <= 1'b0; fire_spread <= 1'b0; fire_pierce <= 1'b0;
      bullet_x <= '0; bullet_y <= '0; bullet_dir <= '0;
      pos_x <= IX; pos_y <= IY; dir <= IDIR; hp <= HP0; alive <= 1'b1; invuln <= 1'b0;
      shield_active <= 1'b0; boost_active <= 1'b0; pierce_count <= '0; spread_count <= '0;
    end else begin
      fire_q      <= fire;
      fire_bullet <= 1'b0;
      fire_spread <= 1'b0;
      fire_pierce <= 1'b0;
      if (game_tick) begin
        if (cd != 8'd0)   cd   <= cd - 8'd1;
        if (fbuf != 8'd0) fbuf <= fbuf - 8'd1;
        if (boost_active) begin
          if (bt == 16'd1) boost_active <= 1'b0;
          bt <= bt - 16'd1;
        end
        if (invuln) begin
          if (it == 16'd1) invuln <= 1'b0;
          it <= it - 16'd1;
        end
      end
      if (fire && !fire_q) fbuf <= FB;

      if (game_start && !armed) begin
        armed <= 1'b1;
        case (skill_type)
          2'd1:    shield_active <= 1'b1;
          2'd2:    pierce_count  <= 3'(PIERCE_INIT);
          2'd3:    spread_count  <= 3'(SPREAD_INIT);
          default: ;
        endcase
      end
      if (use_skill && (skill_type == 2'd0) && alive && armed && !boost_active) begin
        boost_active <= 1'b1;
        bt           <= BT;
      end

      if (do_fire) begin
        fire_bullet <= 1'b1;
        bullet_x    <= bx;
        bullet_y    <= by;
        bullet_dir  <= dir;
        cd          <= FC;
        fbuf        <= 8'd0;
        if (spread_count != 3'd0) begin
          fire_spread  <= 1'b1;
          spread_count <= spread_count - 3'd1;
        end
        if (pierce_count != 3'd0) begin
          fire_pierce  <= 1'b1;
          pierce_count <= pierce_count - 3'd1;
        end
      end

      // Probe k's wall result arrives one cycle later, so the PROBE cycle for k=0 ignores hit_wall.
      case (state)
        IDLE: if (do_move) begin
          dir <= mdir;
          if ((nx != pos_x) || (ny != pos_y)) begin
            state       <= PROBE;
            check_valid <= 1'b1;
            check_x     <= px;
            check_y     <= py;
            k           <= 4'd0;
            blk         <= 1'b0;
            nx_r        <= nx;
            ny_r        <= ny;
            vert        <= ~mdir[1];
          end
        end
        PROBE: begin
          if (k != 4'd0) blk <= blk | hit_wall;
          if (k == nlast) begin
            state       <= DRAIN;
            check_valid <= 1'b0;
          end else begin
            k <= k + 4'd1;
            if (vert) check_x <= check_x + 8'd1;
            else      check_y <= check_y + 8'd1;
          end
        end
        DRAIN: begin
          state <= IDLE;
          if (!kill && !(blk | hit_wall)) begin
            pos_x <= nx_r;
            pos_y <= ny_r;
          end
        end
        default: state <= IDLE;
      endcase

      if (take) begin
        if (shield_active) begin
          shield_active <= 1'b0;
          if (INVULN_TICKS != 0) begin invuln <= 1'b1; it <= IT; end
        end else begin
          hp <= hp - 3'd1;
          if (hp == 3'd1) begin
            alive       <= 1'b0;
            state       <= IDLE;
            check_valid <= 1'b0;
            rt          <= RT;
          end else if (INVULN_TICKS != 0) begin
            invuln <= 1'b1;
            it     <= IT;
          end
        end
      end

      if (!alive && game_tick && (RESPAWN_TICKS != 0) && (rt != 16'd0)) begin
        rt <= rt - 16'd1;
        if (rt == 16'd1) begin
          pos_x <= IX; pos_y <= IY; dir <= IDIR; hp <= HP0; alive <= 1'b1;
          if (INVULN_TICKS != 0) begin invuln <= 1'b1; it <= IT; end
        end
      end
    end
  end
endmodule

// File: tb/tb_tank_unit.sv
// Directed bench for tank_unit: fire/ammo, wall-checked moves, fire buffering,
// shield/hp/invulnerability, boost and death-abort with timed respawn.
module tb_tank_unit;
  logic       clk = 0, rstn = 0, game_tick = 0, game_start = 0;
  logic       move_up = 0, move_down = 0, move_left = 0, move_right = 0;
  logic       fire = 0, use_skill = 0, hit_wall = 0, hit = 0;
  logic [1:0] skill_type = 0;
  logic [7:0] check_x, check_y, bullet_x, bullet_y, pos_x, pos_y;
  logic       check_valid, fire_bullet, fire_spread, fire_pierce;
  logic [1:0] bullet_dir, dir;
  logic [2:0] hp, pierce_count, spread_count;
  logic       alive, invuln, busy, shield_active, boost_active;

  int checks = 0, errors = 0;

  tank_unit #(.RESPAWN_TICKS(10)) dut (
    .clk(clk), .rstn(rstn), .game_tick(game_tick), .game_start(game_start),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .fire(fire), .use_skill(use_skill), .skill_type(skill_type),
    .check_x(check_x), .check_y(check_y), .check_valid(check_valid), .hit_wall(hit_wall),
    .hit(hit), .fire_bullet(fire_bullet), .fire_spread(fire_spread), .fire_pierce(fire_pierce),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_dir(bullet_dir),
    .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .hp(hp), .alive(alive), .invuln(invuln),
    .busy(busy), .shield_active(shield_active), .boost_active(boost_active),
    .pierce_count(pierce_count), .spread_count(spread_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    game_tick = 1; step(); game_tick = 0;
  endtask

  task automatic do_reset();
    rstn = 0; step(); step(); rstn = 1;
  endtask

  task automatic arm(input logic [1:0] t);
    skill_type = t; game_start = 1; step(); game_start = 0;
  endtask

  task automatic press_fire();
    fire = 1; step(); fire = 0; step();
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst_pos_x", pos_x, 20);
    chk("rst_pos_y", pos_y, 70);
    chk("rst_dir", dir, 3);
    chk("rst_hp", hp, 3);
    chk("rst_alive", alive, 1);
    chk("rst_valid", check_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pierce", pierce_count, 0);
    chk("rst_shield", shield_active, 0);
    chk("rst_chk_x", check_x, 0);
    rstn = 1;

    // pierce skill and first shot
    arm(2'd2);
    chk("arm_pierce", pierce_count, 3);
    press_fire();
    tick();
    chk("fire_pulse", fire_bullet, 1);
    chk("fire_pierce", fire_pierce, 1);
    chk("fire_spread", fire_spread, 0);
    chk("pierce_dec", pierce_count, 2);
    chk("bullet_x", bullet_x, 23);
    chk("bullet_y", bullet_y, 72);
    chk("bullet_dir", bullet_dir, 3);
    step();
    chk("fire_one_pulse", fire_bullet, 0);

    // clear move right: probes (23,70..73), commit at T+6
    move_right = 1; tick(); move_right = 0;
    chk("mv_valid1", check_valid, 1);
    chk("mv_busy1", busy, 1);
    chk("mv_cx", check_x, 23);
    chk("mv_cy0", check_y, 70);
    step(); chk("mv_cy1", check_y, 71);
    step(); chk("mv_cy2", check_y, 72);
    step(); chk("mv_cy3", check_y, 73); chk("mv_valid4", check_valid, 1);
    step(); chk("mv_valid5", check_valid, 0); chk("mv_busy5", busy, 1); chk("mv_pos5", pos_x, 20);
    step(); chk("mv_pos6", pos_x, 21); chk("mv_busy6", busy, 0);

    // blocked move: wall on third probe only
    move_right = 1; tick(); move_right = 0;
    chk("blk_cx", check_x, 24);
    step(); step();
    chk("blk_cy2", check_y, 72);
    step();
    hit_wall = 1; step(); hit_wall = 0;
    step();
    chk("blk_pos", pos_x, 21);
    chk("blk_busy", busy, 0);

    // fire buffering against cooldown
    do_reset();
    arm(2'd2);
    press_fire();
    tick(); chk("buf_first", fire_bullet, 1);
    repeat (12) tick();
    press_fire();
    for (int i = 0; i < 3; i++) begin
      tick(); chk("buf_wait", fire_bullet, 0);
    end
    tick();
    chk("buf_fire", fire_bullet, 1);
    chk("buf_pierce", pierce_count, 1);
    press_fire();
    for (int i = 0; i < 16; i++) begin
      tick(); chk("buf_expire", fire_bullet, 0);
    end

    // boost doubles speed
    do_reset();
    arm(2'd0);
    use_skill = 1; step(); use_skill = 0;
    chk("boost_on", boost_active, 1);
    move_right = 1; tick(); move_right = 0;
    chk("boost_cx", check_x, 24);
    repeat (5) step();
    chk("boost_pos", pos_x, 22);

    // shield, hp loss and invulnerability
    do_reset();
    arm(2'd1);
    chk("shield_on", shield_active, 1);
    hit = 1; step(); hit = 0;
    chk("shield_off", shield_active, 0);
    chk("shield_hp", hp, 3);
    chk("shield_inv", invuln, 1);
    hit = 1; step(); hit = 0;
    chk("inv_hp", hp, 3);
    repeat (29) tick();
    chk("inv_hold", invuln, 1);
    tick();
    chk("inv_end", invuln, 0);
    hit = 1; step(); hit = 0;
    chk("hit1_hp", hp, 2);
    chk("hit1_inv", invuln, 1);
    repeat (30) tick();
    hit = 1; step(); hit = 0;
    chk("hit2_hp", hp, 1);
    chk("hit2_alive", alive, 1);

    // death mid-probe aborts move, then respawn after 10 ticks
    repeat (30) tick();
    chk("pre_kill_inv", invuln, 0);
    move_up = 1; tick(); move_up = 0;
    chk("up_dir", dir, 0);
    chk("up_cy", check_y, 69);
    chk("up_valid", check_valid, 1);
    step();
    hit = 1; step(); hit = 0;
    chk("kill_alive", alive, 0);
    chk("kill_hp", hp, 0);
    chk("kill_valid", check_valid, 0);
    chk("kill_busy", busy, 0);
    repeat (3) step();
    chk("kill_pos_y", pos_y, 70);
    repeat (9) tick();
    chk("resp_wait", alive, 0);
    tick();
    chk("resp_alive", alive, 1);
    chk("resp_pos_x", pos_x, 20);
    chk("resp_pos_y", pos_y, 70);
    chk("resp_dir", dir, 3);
    chk("resp_hp", hp, 3);
    chk("resp_inv", invuln, 1);
    chk("resp_shield", shield_active, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
